// File: rtl/mips_pipeline_pkg.sv
// Shared constants and types for the MIPS32 pipeline control blocks.
package mips_pipeline_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG       = 0;

  // Hazard sequencer states.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

endpackage : mips_pipeline_pkg

// File: rtl/load_use_hazard_detect.sv
// Combinational load-use comparator: flags an ID source that depends on a load in EX.
module load_use_hazard_detect #(
  parameter int unsigned REG_ADDR_WIDTH = mips_pipeline_pkg::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_ex_mem_read,
  input  logic                      id_ex_write_destination_reg,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  output logic                      load_use
);

  import mips_pipeline_pkg::*;

  logic rd_live;
  logic rs_match;
  logic rt_match;

  // $zero never carries a real dependency, so a load targeting it cannot stall.
  always_comb begin
    rd_live  = id_ex_mem_read & id_ex_write_destination_reg &
               (id_ex_rd != REG_ADDR_WIDTH'(ZERO_REG));
    rs_match = id_uses_rs & (id_rs == id_ex_rd);
    rt_match = id_uses_rt & (id_rt == id_ex_rd);
    load_use = rd_live & (rs_match | rt_match);
  end

endmodule : load_use_hazard_detect

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush and
// multi-cycle mul/div handshake, plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_WIDTH  = mips_pipeline_pkg::REG_ADDR_WIDTH,
  parameter int unsigned MD_TIMEOUT      = 64,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rt,
  input  logic                       id_uses_rs,
  input  logic                       id_uses_rt,
  input  logic                       id_is_muldiv,
  input  logic                       id_ex_mem_read,
  input  logic                       id_ex_write_destination_reg,
  input  logic [REG_ADDR_WIDTH-1:0]  id_ex_rd,
  input  logic                       ex_branch_taken,
  input  logic                       md_done,
  output logic                       pc_write,
  output logic                       if_id_write,
  output logic                       if_id_flush,
  output logic                       id_ex_bubble,
  output logic                       md_start,
  output logic                       md_error,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  import mips_pipeline_pkg::*;

  // Counter must be able to hold MD_TIMEOUT itself.
  localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT + 1);

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   wait_d;
  logic                set_error;
  logic                load_use;

  load_use_hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_load_use (
    .id_rs                       (id_rs),
    .id_rt                       (id_rt),
    .id_uses_rs                  (id_uses_rs),
    .id_uses_rt                  (id_uses_rt),
    .id_ex_mem_read              (id_ex_mem_read),
    .id_ex_write_destination_reg (id_ex_write_destination_reg),
    .id_ex_rd                    (id_ex_rd),
    .load_use                    (load_use)
  );

  // Mealy next-state and control outputs; hazards resolve in the same cycle.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    set_error    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    md_start     = 1'b0;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      wait_d       = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            // ID instruction is squashed, so its hazards are irrelevant.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_is_muldiv) begin
            md_start     = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = MD_WAIT;
            wait_d       = '0;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state_d = RUN;
          end else if (wait_q == WAIT_W'(MD_TIMEOUT)) begin
            // Give up on the unit but let the instruction advance.
            set_error = 1'b1;
            state_d   = RUN;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            wait_d       = wait_q + WAIT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      wait_q       <= '0;
      md_error     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_error) begin
        md_error <= 1'b1;
      end
      if (!pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
      end
    end
  end

endmodule : pipeline_hazard_controller

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized bench for pipeline_hazard_controller: two instances (default and
// short mul/div timeout) share stimulus and are checked against a rule model.
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_ex_rd;
  logic        id_uses_rs, id_uses_rt, id_is_muldiv;
  logic        id_ex_mem_read, id_ex_write_destination_reg;
  logic        ex_branch_taken, md_done;

  logic        pc_write0, if_id_write0, if_id_flush0, id_ex_bubble0, md_start0, md_error0;
  logic [31:0] stall_cycles0;
  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, md_start1, md_error1;
  logic [31:0] stall_cycles1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state per instance.
  int          tmo      [2] = '{64, 4};
  bit          m_wait   [2];
  int          m_elapsed[2];
  bit          m_err    [2];
  longint      m_stall  [2];
  bit          m_known  = 1'b0;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .MD_TIMEOUT(64), .STALL_CNT_WIDTH(32)) dut0 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_write_destination_reg(id_ex_write_destination_reg), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .pc_write(pc_write0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
    .id_ex_bubble(id_ex_bubble0), .md_start(md_start0), .md_error(md_error0),
    .stall_cycles(stall_cycles0)
  );

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .MD_TIMEOUT(4), .STALL_CNT_WIDTH(32)) dut1 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_write_destination_reg(id_ex_write_destination_reg), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_bubble(id_ex_bubble1), .md_start(md_start1), .md_error(md_error1),
    .stall_cycles(stall_cycles1)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare both instances mid-cycle, advance model.
  task automatic run_cycle(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic mdv,
                           input logic mr, input logic wr, input logic [4:0] rd,
                           input logic br, input logic done);
    bit e_pc, e_ifw, e_fl, e_bub, e_st, lu, fin;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_muldiv = mdv; id_ex_mem_read = mr; id_ex_write_destination_reg = wr;
    id_ex_rd = rd; ex_branch_taken = br; md_done = done;
    #4;
    lu = mr && wr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    for (int i = 0; i < 2; i++) begin
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_st = 0;
      if (rst) begin
        e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
      end else if (!m_wait[i]) begin
        if (br) begin e_fl = 1; e_bub = 1; end
        else if (lu) begin e_pc = 0; e_ifw = 0; e_bub = 1; end
        else if (mdv) begin e_st = 1; e_pc = 0; e_ifw = 0; e_bub = 1; end
      end else begin
        fin = done || (m_elapsed[i] == tmo[i]);
        if (!fin) begin e_pc = 0; e_ifw = 0; e_bub = 1; end
      end
      check($sformatf("pc_write%0d", i),     i == 0 ? pc_write0     : pc_write1,     e_pc);
      check($sformatf("if_id_write%0d", i),  i == 0 ? if_id_write0  : if_id_write1,  e_ifw);
      check($sformatf("if_id_flush%0d", i),  i == 0 ? if_id_flush0  : if_id_flush1,  e_fl);
      check($sformatf("id_ex_bubble%0d", i), i == 0 ? id_ex_bubble0 : id_ex_bubble1, e_bub);
      check($sformatf("md_start%0d", i),     i == 0 ? md_start0     : md_start1,     e_st);
      if (m_known) begin
        check($sformatf("md_error%0d", i),     i == 0 ? md_error0     : md_error1,     m_err[i]);
        check($sformatf("stall_cycles%0d", i), i == 0 ? stall_cycles0 : stall_cycles1, 32'(m_stall[i]));
      end
      // Model next state.
      if (rst) begin
        m_wait[i] = 0; m_elapsed[i] = 0; m_err[i] = 0; m_stall[i] = 0;
      end else begin
        if (!m_wait[i]) begin
          if (!br && !lu && mdv) begin m_wait[i] = 1; m_elapsed[i] = 0; end
        end else if (done) begin
          m_wait[i] = 0;
        end else if (m_elapsed[i] == tmo[i]) begin
          m_wait[i] = 0; m_err[i] = 1;
        end else begin
          m_elapsed[i]++;
        end
        if (!e_pc && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
      end
    end
    if (rst) m_known = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    check("reset_stall", stall_cycles0, 32'd0);
    check("reset_err",   32'(md_error0), 32'd0);

    // Load-use: lw $8 in EX, add reading $8 in ID.
    run_cycle(0, 5'd8, 5'd3, 1, 1, 0, 1, 1, 5'd8, 0, 0);
    idle(1);
    check("lu_stall", stall_cycles0, 32'd1);

    // $zero destination and unused rt never stall.
    run_cycle(0, 5'd0, 5'd3, 1, 1, 0, 1, 1, 5'd0, 0, 0);
    run_cycle(0, 5'd4, 5'd8, 1, 0, 0, 1, 1, 5'd8, 0, 0);
    check("zero_stall", stall_cycles0, 32'd1);

    // Branch beats load-use.
    run_cycle(0, 5'd8, 5'd3, 1, 1, 0, 1, 1, 5'd8, 1, 0);
    check("br_stall", stall_cycles0, 32'd1);

    // Mul/div: start, 5 wait cycles, done advances. Short-timeout copy aborts.
    do_reset();
    run_cycle(0, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 0);
    idle(5);
    run_cycle(0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 1);
    idle(1);
    check("md_stall",     stall_cycles0, 32'd6);
    check("md_err",       32'(md_error0), 32'd0);
    check("tmo_err",      32'(md_error1), 32'd1);
    check("tmo_stall",    stall_cycles1, 32'd5);

    // Reset mid-wait clears everything without an error.
    run_cycle(0, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 0);
    idle(2);
    do_reset();
    check("rst_wait_err",   32'(md_error0) | 32'(md_error1), 32'd0);
    check("rst_wait_stall", stall_cycles0 | stall_cycles1, 32'd0);

    // Randomized traffic with small register space to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      run_cycle(($urandom_range(0, 199) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_hazard_controller
